// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus M-extension multiply/divide sequencer.
package kamus_pkg;

   localparam int MULDIV_STEPS = 32;

   // Encoding matches funct3 of the OP/M instruction group.
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIX,
      ST_DONE
   } muldiv_state_e;

   function automatic logic is_div_op(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/kamus_muldiv_dp.sv
// Operand, product/remainder and result registers for the iterative mul/div unit,
// advanced by load/prep/step/fix strobes from the controlling FSM.
module kamus_muldiv_dp
   import kamus_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic            prep_i,
   input  logic            step_i,
   input  logic            fix_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            special_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_op_e        op_q;
   logic [XLEN-1:0]   a_q, b_q, addend_q, res_q;
   logic [2*XLEN-1:0] acc_q;
   logic              neg_q, neg_rem_q;

   logic              div_op, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, special_res, fix_res;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, prod_fix;

   // acc_q holds {upper, lower}: product for multiply, {remainder, dividend/quotient} for divide.
   always_comb begin
      div_op   = is_div_op(op_q);
      a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
      b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      a_neg    = a_signed & a_q[XLEN-1];
      b_neg    = b_signed & b_q[XLEN-1];
      a_mag    = a_neg ? -a_q : a_q;
      b_mag    = b_neg ? -b_q : b_q;
      div_zero = div_op && (b_q == '0);
      div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_INT) && (b_q == '1);

      special_res = '0;
      if (div_zero)
         special_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
      else if (div_ovf)
         special_res = (op_q == OP_DIV) ? MIN_INT : '0;

      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, addend_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

      prod_fix = neg_q ? -acc_q : acc_q;
      case (op_q)
         OP_MUL:                     fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:            fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
         default:                    fix_res = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         op_q      <= OP_MUL;
         a_q       <= '0;
         b_q       <= '0;
         addend_q  <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         if (load_i) begin
            op_q <= muldiv_op_e'(op_i);
            a_q  <= rs1_data_i;
            b_q  <= rs2_data_i;
         end
         if (prep_i) begin
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (div_op) begin
               acc_q    <= {{XLEN{1'b0}}, a_mag};
               addend_q <= b_mag;
            end else begin
               acc_q    <= {{XLEN{1'b0}}, b_mag};
               addend_q <= a_mag;
            end
            if (div_zero || div_ovf)
               res_q <= special_res;
         end
         if (step_i)
            acc_q <= div_op ? div_next : mul_next;
         if (fix_i)
            res_q <= fix_res;
      end
   end

   assign special_o = div_zero | div_ovf;
   assign result_o  = res_q;

endmodule

// File: rtl/kamus_muldiv_ctrl.sv
// Sequencer for RV32M ops: accepts an op from EX, stalls the pipe while the
// datapath iterates, and presents one result with a single-cycle valid pulse.
module kamus_muldiv_ctrl
   import kamus_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int STEPS = MULDIV_STEPS
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o
);

   muldiv_state_e   state_q;
   logic [5:0]      cnt_q;
   logic [XLEN-1:0] last_q;
   logic            accept, special;
   logic [XLEN-1:0] dp_result;

   assign accept = (state_q == ST_IDLE) && start_i && !flush_i;

   kamus_muldiv_dp #(.XLEN(XLEN)) u_dp (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (accept),
      .prep_i     ((state_q == ST_PREP) && !flush_i),
      .step_i     ((state_q == ST_CALC) && !flush_i),
      .fix_i      ((state_q == ST_FIX)  && !flush_i),
      .op_i       (op_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .special_o  (special),
      .result_o   (dp_result)
   );

   // A flush in any busy state abandons the op; last_q only moves on an unflushed DONE.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) state_q <= ST_PREP;
            ST_PREP: begin
               if (flush_i)
                  state_q <= ST_IDLE;
               else if (special)
                  state_q <= ST_DONE;
               else begin
                  cnt_q   <= '0;
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (flush_i)
                  state_q <= ST_IDLE;
               else begin
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == 6'(STEPS-1))
                     state_q <= ST_FIX;
               end
            end
            ST_FIX:  state_q <= flush_i ? ST_IDLE : ST_DONE;
            ST_DONE: begin
               if (!flush_i)
                  last_q <= dp_result;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign stall_o  = !flush_i && (accept || (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX));
   assign busy_o   = (state_q != ST_IDLE);
   assign valid_o  = (state_q == ST_DONE) && !flush_i;
   assign result_o = valid_o ? dp_result : last_q;

endmodule

// File: tb/tb_kamus_muldiv_ctrl.sv
// Scoreboard bench for kamus_muldiv_ctrl: directed RV32M cases, flush/reset
// interruptions and random ops checked against an arithmetic reference model.
module tb_kamus_muldiv_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni, start_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_data_i, rs2_data_i;
   logic        stall_o, busy_o, valid_o;
   logic [31:0] result_o;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_res = '0;

   kamus_muldiv_ctrl dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .op_i       (op_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // RV32M semantics computed with wide integer arithmetic.
   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, p;
      logic [63:0] up;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: return a * b;
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000;
               else return 32'($signed(a) / $signed(b));
         3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
         3'd6: if (b == 0) return a; else if (ovf) return 32'h0;
               else return 32'($signed(a) % $signed(b));
         default: if (b == 0) return a; else return a % b;
      endcase
   endfunction

   function automatic logic isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Drives start for one cycle; must be called while the DUT is idle.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start_i    = 1'b1;
      flush_i    = 1'b0;
      op_i       = op;
      rs1_data_i = a;
      rs2_data_i = b;
      exp_q.push_back('{res: refModel(op, a, b), due: cyc + (isSpecial(op, a, b) ? 2 : 35)});
      #1 checkOutput("stall_on_accept", {31'b0, stall_o}, 32'd1);
      @(negedge clk_i);
      start_i    = 1'b0;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
   endtask

   task automatic waitIdle(input int exp_stalls);
      int n = 0;
      int stalls = 0;
      #1;
      while (busy_o && n < 100) begin
         if (stall_o) stalls++;
         n++;
         @(negedge clk_i);
         #1;
      end
      if (n >= 100) checkOutput("idle_timeout", 32'd1, 32'd0);
      checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
   endtask

   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = refModel(op, a, b);
      applyStimulus(op, a, b);
      waitIdle(isSpecial(op, a, b) ? 1 : 34);
      last_res = r;
      checkOutput("result_hold", result_o, last_res);
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #1;
         if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("result", result_o, e.res);
               checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
               checkOutput("stall_in_done", {31'b0, stall_o}, 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
      op_i = 3'd0; rs1_data_i = '0; rs2_data_i = '0;
      repeat (3) @(negedge clk_i);
      #1;
      checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("reset_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("reset_stall", {31'b0, stall_o}, 32'd0);
      checkOutput("reset_result", result_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      runOp(3'd0, 32'd7, 32'hFFFF_FFFD);
      runOp(3'd1, 32'h8000_0000, 32'h8000_0000);
      runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      runOp(3'd2, 32'hFFFF_FFFF, 32'd2);
      runOp(3'd4, 32'hFFFF_FFF9, 32'd2);
      runOp(3'd6, 32'hFFFF_FFF9, 32'd2);
      runOp(3'd5, 32'd100, 32'd7);
      runOp(3'd7, 32'd100, 32'd7);
      runOp(3'd5, 32'd7, 32'd0);
      runOp(3'd6, 32'd7, 32'd0);
      runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // Flush during a multiply, then an immediate new op.
      runOp(3'd0, 32'd5, 32'd6);
      applyStimulus(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(negedge clk_i);
      flush_i = 1'b1;
      void'(exp_q.pop_back());
      #1;
      checkOutput("flush_stall", {31'b0, stall_o}, 32'd0);
      checkOutput("flush_valid", {31'b0, valid_o}, 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      checkOutput("flush_idle", {31'b0, busy_o}, 32'd0);
      checkOutput("flush_result_hold", result_o, last_res);
      runOp(3'd1, 32'hFFFF_FFF0, 32'd3);

      // Reset in the middle of a multiply.
      applyStimulus(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      repeat (19) @(negedge clk_i);
      rst_ni = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk_i);
      #1;
      checkOutput("midreset_busy", {31'b0, busy_o}, 32'd0);
      checkOutput("midreset_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("midreset_stall", {31'b0, stall_o}, 32'd0);
      checkOutput("midreset_result", result_o, 32'd0);
      rst_ni = 1'b1;
      last_res = '0;
      @(negedge clk_i);

      // start together with flush in IDLE must be ignored.
      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5;
      rs1_data_i = 32'd9; rs2_data_i = 32'd3;
      #1 checkOutput("startflush_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk_i);
      #1 checkOutput("startflush_busy", {31'b0, busy_o}, 32'd0);
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);

      for (int i = 0; i < 30; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra, rb;
         rop = 3'($urandom_range(0, 7));
         ra  = pickOperand();
         rb  = pickOperand();
         runOp(rop, ra, rb);
      end

      repeat (3) @(negedge clk_i);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
